// File: rtl/hvac_pkg.sv
// Shared state codes, default thresholds and timer sizing for the HVAC sequencer.
package hvac_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEAT    = 2'd1;
    localparam logic [1:0] COOL    = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_HEAT    = HEAT,
        ST_COOL    = COOL,
        ST_LOCKOUT = LOCKOUT
    } hvac_state_e;

    localparam logic [4:0]  HEAT_ON_DEF     = 5'd18;
    localparam logic [4:0]  HEAT_OFF_DEF    = 5'd20;
    localparam logic [4:0]  COOL_ON_DEF     = 5'd22;
    localparam logic [4:0]  COOL_OFF_DEF    = 5'd20;
    localparam int unsigned MIN_RUN_DEF     = 8;
    localparam int unsigned MIN_OFF_DEF     = 4;
    localparam int unsigned FAN_OVERRUN_DEF = 2;

    // Bits needed to hold the larger of two dwell lengths minus one, never below 1.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hvac_dwell_timer.sv
// Loadable down-counter that parks at zero; used for dwell and fan-overrun timing.
module dwell_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/hvac_sequencer.sv
// Thermostat sequencer: hysteresis, minimum run/off times and fan overrun around
// registered heating/cooling/fan drives.
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter logic [4:0]  HEAT_ON     = HEAT_ON_DEF,
    parameter logic [4:0]  HEAT_OFF    = HEAT_OFF_DEF,
    parameter logic [4:0]  COOL_ON     = COOL_ON_DEF,
    parameter logic [4:0]  COOL_OFF    = COOL_OFF_DEF,
    parameter int unsigned MIN_RUN     = MIN_RUN_DEF,
    parameter int unsigned MIN_OFF     = MIN_OFF_DEF,
    parameter int unsigned FAN_OVERRUN = FAN_OVERRUN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [4:0] temperature,
    output logic       heating,
    output logic       cooling,
    output logic       fan,
    output logic [1:0] state,
    output logic       busy
);

    localparam int unsigned TW = timer_width(MIN_RUN, MIN_OFF);
    localparam logic [TW-1:0] RUN_LOAD = TW'(MIN_RUN - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(MIN_OFF - 1);
    localparam logic [TW-1:0] FAN_LOAD = (FAN_OVERRUN > 0) ? TW'(FAN_OVERRUN - 1) : '0;
    localparam bit PARAMS_OK = (HEAT_ON <= HEAT_OFF) && (HEAT_OFF <= COOL_OFF) &&
                               (COOL_OFF <= COOL_ON) && (MIN_RUN >= 1) &&
                               (MIN_OFF >= 1) && (FAN_OVERRUN <= MIN_OFF);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("hvac_sequencer: illegal threshold or timing parameters");
        end
    endgenerate

    hvac_state_e state_reg, state_next;
    logic heating_reg, heating_next;
    logic cooling_reg, cooling_next;
    logic fan_reg, fan_next;

    // Timer 0 times the dwell in HEAT/COOL/LOCKOUT, timer 1 the fan overrun.
    logic [1:0]    tmr_load;
    logic [TW-1:0] tmr_load_val [2];
    logic [1:0]    tmr_zero;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_timer
            dwell_timer #(.WIDTH(TW)) u_timer (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (tmr_load[gi]),
                .load_val (tmr_load_val[gi]),
                .zero     (tmr_zero[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            heating_reg <= 1'b0;
            cooling_reg <= 1'b0;
            fan_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            heating_reg <= heating_next;
            cooling_reg <= cooling_next;
            fan_reg     <= fan_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable && (temperature < HEAT_ON)) begin
                    state_next = ST_HEAT;
                end else if (enable && (temperature > COOL_ON)) begin
                    state_next = ST_COOL;
                end
            end
            ST_HEAT: begin
                if (!enable || (tmr_zero[0] && (temperature >= HEAT_OFF))) begin
                    state_next = ST_LOCKOUT;
                end
            end
            ST_COOL: begin
                if (!enable || (tmr_zero[0] && (temperature <= COOL_OFF))) begin
                    state_next = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero[0]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decided from the next state so they change on the same edge as it.
    always_comb begin
        tmr_load[0]     = (state_next != state_reg) && (state_next != ST_IDLE);
        tmr_load_val[0] = (state_next == ST_LOCKOUT) ? OFF_LOAD : RUN_LOAD;
        tmr_load[1]     = (state_next == ST_LOCKOUT) && (state_reg != ST_LOCKOUT);
        tmr_load_val[1] = FAN_LOAD;

        heating_next = (state_next == ST_HEAT);
        cooling_next = (state_next == ST_COOL);
        fan_next     = heating_next || cooling_next;
        if (state_next == ST_LOCKOUT) begin
            if (tmr_load[1]) begin
                fan_next = (FAN_OVERRUN > 0);
            end else begin
                fan_next = fan_reg && !tmr_zero[1];
            end
        end
    end

    assign heating = heating_reg;
    assign cooling = cooling_reg;
    assign fan     = fan_reg;
    assign state   = state_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed plus randomized check of hvac_sequencer against a dwell-counting mode model.
module tb_hvac_sequencer;

    localparam int T_HEAT_ON  = 18;
    localparam int T_HEAT_OFF = 20;
    localparam int T_COOL_ON  = 22;
    localparam int T_COOL_OFF = 20;
    localparam int T_MIN_RUN  = 8;
    localparam int T_MIN_OFF  = 4;
    localparam int T_OVERRUN  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [4:0] temperature;
    logic       heating, cooling, fan, busy;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int m_mode  = 0;   // 0 idle, 1 heat, 2 cool, 3 lockout
    int m_dwell = 0;   // cycles already spent in m_mode
    logic [1:0] prev_state = 2'd0;

    hvac_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .temperature (temperature),
        .heating     (heating),
        .cooling     (cooling),
        .fan         (fan),
        .state       (state),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0d, required %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic enter(input int mode);
        m_mode  = mode;
        m_dwell = 0;
    endtask

    task automatic model_step(input bit en, input int t);
        case (m_mode)
            0: begin
                if (en && t < T_HEAT_ON) enter(1);
                else if (en && t > T_COOL_ON) enter(2);
            end
            1: begin
                if (!en || (m_dwell >= T_MIN_RUN - 1 && t >= T_HEAT_OFF)) enter(3);
                else m_dwell++;
            end
            2: begin
                if (!en || (m_dwell >= T_MIN_RUN - 1 && t <= T_COOL_OFF)) enter(3);
                else m_dwell++;
            end
            default: begin
                if (m_dwell >= T_MIN_OFF - 1) enter(0);
                else m_dwell++;
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        logic exp_fan;
        logic adj;
        exp_fan = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && m_dwell < T_OVERRUN);
        adj = (prev_state == 2'd1 && state == 2'd2) || (prev_state == 2'd2 && state == 2'd1);
        $display("[%s] cyc=%0d rst_n=%0b en=%0b t=%0d -> state=%0d h=%0b c=%0b f=%0b busy=%0b (model mode=%0d dwell=%0d)",
                 tag, cyc, rst_n, enable, temperature, state, heating, cooling, fan, busy, m_mode, m_dwell);
        check_eq({tag, ".state"},   8'(state),   8'(m_mode));
        check_eq({tag, ".heating"}, 8'(heating), 8'(m_mode == 1));
        check_eq({tag, ".cooling"}, 8'(cooling), 8'(m_mode == 2));
        check_eq({tag, ".fan"},     8'(fan),     8'(exp_fan));
        check_eq({tag, ".busy"},    8'(busy),    8'(m_mode != 0));
        check_eq({tag, ".heat_and_cool"}, 8'(heating & cooling), 8'd0);
        check_eq({tag, ".run_without_fan"}, 8'((heating | cooling) & ~fan), 8'd0);
        check_eq({tag, ".heat_cool_adjacent"}, 8'(adj), 8'd0);
        prev_state = state;
    endtask

    // Called at a falling edge; drives inputs, lets one rising edge pass, checks.
    task automatic step(input string tag, input bit en, input int t);
        enable      = en;
        temperature = 5'(t);
        @(posedge clk);
        cyc++;
        model_step(en, t);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must drop at once.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        cyc++;
        #3;
        rst_n = 1'b0;
        #1;
        enter(0);
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        bit en;
        rst_n       = 1'b0;
        enable      = 1'b1;
        temperature = 5'd15;
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // Cold start, then warm up: minimum run, overrun, lockout, idle.
        step("cold_start", 1'b1, 15);
        step("heat", 1'b1, 15);
        repeat (14) step("heat_to_idle", 1'b1, 21);

        // Hysteresis band in IDLE and during HEAT.
        repeat (4) step("idle_band", 1'b1, 19);
        step("heat_again", 1'b1, 10);
        repeat (20) step("heat_band", 1'b1, 19);

        // Hot: heat ends, lockout, cool, then cold: lockout, idle, heat.
        repeat (16) step("go_cool", 1'b1, 25);
        repeat (16) step("cool_to_heat", 1'b1, 10);
        repeat (14) step("settle", 1'b1, 21);

        // Safety override in the third HEAT cycle.
        repeat (3) step("heat_pre_drop", 1'b1, 10);
        repeat (10) step("enable_low", 1'b0, 10);

        // Extreme readings.
        repeat (3) step("temp0", 1'b1, 0);
        repeat (14) step("temp31", 1'b1, 31);

        // Asynchronous reset while cooling.
        repeat (3) step("cool_pre_reset", 1'b1, 25);
        mid_reset("reset_mid_cool");
        step("after_reset", 1'b1, 21);

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) < 8) t = int'($urandom_range(14, 26));
            else t = int'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) mid_reset("rand_reset");
            else step("rand", en, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
